// File: rtl/bidir_visitor_counter_pkg.sv
// visitor_pkg: shared mode selectors and default sizing for the visitor counter
package visitor_pkg;
  localparam int MODE_SAT      = 0;
  localparam int MODE_WRAP     = 1;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_COUNT = 100;
  localparam int DEF_DEBOUNCE  = 4;
endpackage

// File: rtl/bidir_visitor_counter_sensor_conditioner.sv
// sensor_conditioner: synchronise, debounce and rising-edge detect one raw sensor
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic evt,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, db_q, db_prev_q, evt_q;
  logic db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // debounce counter runs only while the synchronised level disagrees with db
  always_comb begin
    cnt_d = (s2_q != db_q && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    db_d  = (s2_q != db_q && cnt_q == LAST) ? s2_q : db_q;
  end
  // synchroniser, debounced level and registered edge pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      evt_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      evt_q     <= db_q & ~db_prev_q;
      cnt_q     <= cnt_d;
    end
  end
  assign evt   = evt_q;
  assign level = db_q;
endmodule

// File: rtl/bidir_visitor_counter.sv
// bidir_visitor_counter: bounded occupancy counter driven by conditioned entry/exit sensors
module bidir_visitor_counter
  import visitor_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int MAX_COUNT       = DEF_MAX_COUNT,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int WRAP_MODE       = MODE_SAT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             entry_evt,
  output logic             exit_evt,
  output logic             overflow,
  output logic             underflow
);
  if (MAX_COUNT < 0 || longint'(MAX_COUNT) > (longint'(1) << WIDTH) - 1) begin : g_bad_max
    $error("MAX_COUNT does not fit in WIDTH bits");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  localparam bit WRAP = (WRAP_MODE == MODE_WRAP);
  logic [WIDTH-1:0] count_q, count_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic inc, dec;
  sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
    .clk(clk), .reset_n(reset_n), .raw(entry_sensor), .evt(entry_evt), .level()
  );
  sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
    .clk(clk), .reset_n(reset_n), .raw(exit_sensor), .evt(exit_evt), .level()
  );
  assign full  = (count_q == MAX);
  assign empty = (count_q == '0);
  assign inc   = enable & entry_evt & ~exit_evt;
  assign dec   = enable & exit_evt & ~entry_evt;
  // clear beats load beats events; simultaneous entry/exit cancel out
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (load) begin
      count_d = (load_value > MAX) ? MAX : load_value;
    end else if (inc) begin
      count_d    = full ? (WRAP ? '0 : count_q) : count_q + 1'b1;
      overflow_d = overflow_q | full;
    end else if (dec) begin
      count_d     = empty ? (WRAP ? MAX : count_q) : count_q - 1'b1;
      underflow_d = underflow_q | empty;
    end
  end
  // occupancy and sticky error registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_bidir_visitor_counter.sv
// tb_bidir_visitor_counter: directed scoreboard bench over three parameterisations
module tb_bidir_visitor_counter;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b1, clear = 1'b0, load = 1'b0;
  logic [7:0] load_value = '0;
  logic entry_sensor = 1'b0, exit_sensor = 1'b0;
  logic [7:0] ca, cs, cw;
  logic fa, ea, a_en, a_ex, oa, ua;
  logic fs, es, s_en, s_ex, os, us;
  logic fw, ew, w_en, w_ex, ow, uw;
  int vecs = 0, errs = 0, n_entry = 0;
  int ma = 0, ms = 0, mw = 0;
  bit moa, mua, mos, mus, mow, muw;
  typedef struct {
    string tag;
    int a, s, w;
    bit oa, ua, os, us, ow, uw;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) if (a_en) n_entry++;

  bidir_visitor_counter #(.WIDTH(8), .MAX_COUNT(100), .DEBOUNCE_CYCLES(4), .WRAP_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load), .load_value(load_value),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor), .count(ca), .full(fa), .empty(ea),
    .entry_evt(a_en), .exit_evt(a_ex), .overflow(oa), .underflow(ua));
  bidir_visitor_counter #(.WIDTH(8), .MAX_COUNT(3), .DEBOUNCE_CYCLES(4), .WRAP_MODE(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load), .load_value(load_value),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor), .count(cs), .full(fs), .empty(es),
    .entry_evt(s_en), .exit_evt(s_ex), .overflow(os), .underflow(us));
  bidir_visitor_counter #(.WIDTH(8), .MAX_COUNT(3), .DEBOUNCE_CYCLES(4), .WRAP_MODE(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load), .load_value(load_value),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor), .count(cw), .full(fw), .empty(ew),
    .entry_evt(w_en), .exit_evt(w_ex), .overflow(ow), .underflow(uw));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void upd(input bit en, input bit ex, input int mx, input bit wrap,
                              inout int c, inout bit o, inout bit u);
    if (en && !ex) begin
      if (c == mx) begin o = 1'b1; c = wrap ? 0 : c; end else c++;
    end else if (ex && !en) begin
      if (c == 0) begin u = 1'b1; c = wrap ? mx : c; end else c--;
    end
  endfunction

  function automatic void model(input bit en, input bit ex);
    upd(en, ex, 100, 1'b0, ma, moa, mua);
    upd(en, ex, 3, 1'b0, ms, mos, mus);
    upd(en, ex, 3, 1'b1, mw, mow, muw);
  endfunction

  function automatic void model_set(input int a, input int s, input int w, input bit flags_too);
    ma = a; ms = s; mw = w;
    if (flags_too) begin moa = 0; mua = 0; mos = 0; mus = 0; mow = 0; muw = 0; end
  endfunction

  function automatic exp_t snap(input string tag);
    return '{tag, ma, ms, mw, moa, mua, mos, mus, mow, muw};
  endfunction

  task automatic cmp(input exp_t e);
    chk({e.tag, "_count_a"}, 32'(ca), e.a);
    chk({e.tag, "_count_s"}, 32'(cs), e.s);
    chk({e.tag, "_count_w"}, 32'(cw), e.w);
    chk({e.tag, "_ovf_a"}, 32'(oa), 32'(e.oa));
    chk({e.tag, "_unf_a"}, 32'(ua), 32'(e.ua));
    chk({e.tag, "_ovf_s"}, 32'(os), 32'(e.os));
    chk({e.tag, "_unf_s"}, 32'(us), 32'(e.us));
    chk({e.tag, "_ovf_w"}, 32'(ow), 32'(e.ow));
    chk({e.tag, "_unf_w"}, 32'(uw), 32'(e.uw));
  endtask

  task automatic sense(input string tag, input bit en, input bit ex);
    int t;
    if (enable) model(en, ex);
    q.push_back(snap(tag));
    entry_sensor = en;
    exit_sensor  = ex;
    t = 0;
    while (t < 40 && !(a_en || a_ex)) begin step; t++; end
    chk({tag, "_evt_seen"}, 32'(a_en || a_ex), 1);
    chk({tag, "_evt_pair"}, 32'({a_en, a_ex}), 32'({en, ex}));
    step;
    cmp(q.pop_front());
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    repeat (10) step;
  endtask

  initial begin
    int n0;
    repeat (3) step;
    chk("rst_count", 32'(ca), 0);
    chk("rst_empty", 32'(ea), 1);
    chk("rst_full", 32'(fa), 0);
    reset_n = 1'b1;
    repeat (20) step;
    cmp(snap("idle"));
    chk("idle_empty", 32'(ea), 1);
    chk("idle_full", 32'(fa), 0);
    chk("idle_no_evt", 32'(n_entry), 0);
    entry_sensor = 1'b1;
    model(1'b1, 1'b0);
    repeat (7) step;
    chk("lat_e6_count", 32'(ca), 0);
    chk("lat_e6_evt", 32'(a_en), 1);
    step;
    chk("lat_e7_evt", 32'(a_en), 0);
    cmp(snap("lat_e7"));
    repeat (2) step;
    entry_sensor = 1'b0;
    repeat (10) step;
    chk("lat_single_evt", 32'(n_entry), 1);
    entry_sensor = 1'b1;
    repeat (2) step;
    entry_sensor = 1'b0;
    repeat (15) step;
    chk("glitch_no_evt", 32'(n_entry), 1);
    cmp(snap("glitch"));
    sense("ent2", 1'b1, 1'b0);
    sense("ent3", 1'b1, 1'b0);
    chk("sat_full_s", 32'(fs), 1);
    sense("ent4", 1'b1, 1'b0);
    sense("ent5", 1'b1, 1'b0);
    chk("sat_full_s2", 32'(fs), 1);
    chk("wrap_w_after5", 32'(cw), 1);
    clear = 1'b1;
    step;
    clear = 1'b0;
    model_set(0, 0, 0, 1'b1);
    cmp(snap("clear"));
    chk("clear_empty_s", 32'(es), 1);
    sense("exit_at0", 1'b0, 1'b1);
    clear = 1'b1;
    step;
    clear = 1'b0;
    load = 1'b1;
    load_value = 8'd3;
    step;
    load = 1'b0;
    model_set(0, 0, 0, 1'b1);
    model_set(3, 3, 3, 1'b0);
    cmp(snap("load3"));
    sense("wrap_ent", 1'b1, 1'b0);
    sense("wrap_exit", 1'b0, 1'b1);
    clear = 1'b1;
    step;
    clear = 1'b0;
    load = 1'b1;
    step;
    load = 1'b0;
    model_set(0, 0, 0, 1'b1);
    model_set(3, 3, 3, 1'b0);
    sense("both_at_max", 1'b1, 1'b1);
    enable = 1'b0;
    n0 = n_entry;
    sense("disabled", 1'b1, 1'b0);
    chk("disabled_pulsed", 32'(n_entry - n0), 1);
    enable = 1'b1;
    entry_sensor = 1'b1;
    repeat (7) step;
    chk("ldevt_evt", 32'(a_en), 1);
    load = 1'b1;
    load_value = 8'd200;
    step;
    load = 1'b0;
    model_set(100, 3, 3, 1'b0);
    cmp(snap("load_clamp"));
    chk("load_full_a", 32'(fa), 1);
    entry_sensor = 1'b0;
    repeat (10) step;
    load = 1'b1;
    load_value = 8'd5;
    step;
    load = 1'b0;
    model_set(5, 3, 3, 1'b0);
    cmp(snap("load5"));
    entry_sensor = 1'b1;
    repeat (3) step;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(ca), 0);
    chk("async_rst_empty", 32'(ea), 1);
    repeat (2) step;
    reset_n = 1'b1;
    n0 = n_entry;
    repeat (6) step;
    chk("post_rst_no_evt", 32'(n_entry - n0), 0);
    chk("post_rst_evt_lo", 32'(a_en), 0);
    step;
    chk("post_rst_evt_hi", 32'(a_en), 1);
    step;
    model_set(0, 0, 0, 1'b1);
    model(1'b1, 1'b0);
    cmp(snap("post_rst"));
    entry_sensor = 1'b0;
    repeat (5) step;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/bidir_visitor_counter.md
Name: bidir_visitor_counter

Overview:
- Parametrised occupancy counter for the room-entry system; successor to the free-running 4-bit up counter.
- Takes raw entry and exit sensor levels and conditions each one: 2-FF synchroniser, debounce, rising-edge detect.
- Counts up on entry and down on exit, between 0 and MAX_COUNT.
- Provides saturate or wrap mode, sync clear, parallel load, enable, full/empty flags and sticky overflow/underflow errors.

Parameters:
- WIDTH, 8: count width in bits.
- MAX_COUNT, 100: room capacity. Must satisfy MAX_COUNT <= 2**WIDTH-1 (elaboration error otherwise).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed before the debounced level changes. Must be >= 1.
- WRAP_MODE, 0: 0 = saturate at bounds; 1 = wrap modulo MAX_COUNT+1.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: when low, detected events are discarded (not queued); sensor conditioning keeps running.
- clear, input, 1: synchronous, sets count to 0 and clears the error flags.
- load, input, 1: synchronous parallel load.
- load_value, input, WIDTH: load data.
- entry_sensor, input, 1: raw asynchronous entry sensor level.
- exit_sensor, input, 1: raw asynchronous exit sensor level.
- count, output, WIDTH: current occupancy.
- full, output, 1: count == MAX_COUNT (combinational from count).
- empty, output, 1: count == 0 (combinational from count).
- entry_evt, output, 1: one-cycle pulse per debounced entry rising edge.
- exit_evt, output, 1: one-cycle pulse per debounced exit rising edge.
- overflow, output, 1: sticky; an entry was applied at MAX_COUNT.
- underflow, output, 1: sticky; an exit was applied at 0.

Behaviour:
- Reset (reset_n low, async): count=0, overflow=0, underflow=0, evt=0, sync/debounce state=0. Hence empty=1, full=0.
- Conditioning, identical per sensor:
  - s1/s2 synchroniser.
  - Debounce counter increments while s2 != db and resets to 0 when s2 == db. When it reaches DEBOUNCE_CYCLES, db <= s2 and the counter resets.
  - evt register <= db & ~db_prev.
- Latency: raw rise before sampling edge E0 -> s2 at E1 -> db at E1+D -> evt high after E2+D -> count updated at E3+D.
  - With D=4, count changes at the 7th edge after E0.
- A glitch shorter than D cycles at s2 produces no event.
- Falling edges and held levels produce no event; one event per debounced rising edge.
- Update priority per edge: clear > load > events.
  - clear: count=0, overflow=0, underflow=0. Events this cycle are dropped.
  - load: count = min(load_value, MAX_COUNT). Flags unchanged; events this cycle are dropped.
  - enable=0: events dropped, count held. entry_evt/exit_evt still pulse.
- Events, with enable=1 and no clear/load:
  - entry only, count<MAX_COUNT: count+1.
  - entry only, count==MAX_COUNT: overflow<=1. WRAP_MODE=0: hold. WRAP_MODE=1: count<=0.
  - exit only, count>0: count-1.
  - exit only, count==0: underflow<=1. WRAP_MODE=0: hold. WRAP_MODE=1: count<=MAX_COUNT.
  - entry and exit in the same cycle: net zero. Count unchanged, no flags set, including at the bounds.
- Arithmetic in WIDTH bits; comparisons against MAX_COUNT cast to WIDTH. No intermediate carry is exposed.
- Reset asserted mid-debounce or mid-pulse: all state cleared immediately. After release, a sensor already high produces an event once it has been stable for D cycles.

Decomposition:
- Package visitor_pkg: mode constants MODE_SAT=0, MODE_WRAP=1; default width/capacity/debounce constants.
- Sub-module sensor_conditioner:
  - Ports: clk, reset_n, raw, evt, level. Parameter DEBOUNCE_CYCLES.
  - Instantiated twice (entry, exit).
- Top holds the count datapath and flags.

Test Plan:
- Reset/idle: reset_n low then high, sensors low for 20 cycles -> count=0, empty=1, full=0, no evt pulses, overflow=underflow=0.
- Latency and glitch, D=4:
  - entry_sensor high for 10 cycles -> single entry_evt, count 0->1 exactly 7 edges after the first sampling edge.
  - 2-cycle entry pulse -> no event, count stays 0.
- Saturation, MAX_COUNT=3, WRAP_MODE=0:
  - 5 debounced entries -> count 1,2,3,3,3; full=1; overflow=1.
  - clear -> count=0, overflow=0.
  - One exit at 0 -> count 0, underflow=1.
- Wrap, MAX_COUNT=3, WRAP_MODE=1:
  - load 3, one entry -> count=0, overflow=1.
  - Then one exit -> count=3, underflow=1.
- Priority/simultaneity:
  - entry_evt and exit_evt in the same cycle at count=3 (MAX) -> count 3, no flags.
  - load=1 with load_value=200 (MAX_COUNT=100) coincident with an entry event -> count=100.
  - enable=0 during an event -> evt pulses, count unchanged.
- Async reset mid-operation: assert reset_n low 2 cycles into a debounce window with count=5 -> count=0 immediately, no event after release until the sensor has been stable for D cycles.
